// File: rtl/run_controller.sv
// Run controller: sequences the core reset, counts run cycles, and latches the halt/timeout verdict.
// Optional AUTO_START_EN: leave IDLE on the first edge after reset release without a start pulse.
module run_controller #(
    parameter int unsigned      RST_HOLD   = 3,
    parameter int unsigned      MAX_CYCLES = 1000,
    parameter int unsigned      CNT_W      = 16,
    parameter int unsigned      SIG_W      = 32,
    parameter logic [SIG_W-1:0] PASS_CODE  = SIG_W'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt,
    input  logic [SIG_W-1:0] halt_code,
    output logic             core_rst,
    output logic             running,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [SIG_W-1:0] result
);

    localparam int unsigned      HOLD_W    = $clog2(RST_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StReset, StRun, StDone} state_e;

    state_e            state_q;
    logic [HOLD_W-1:0] hold_q;
    logic              go_reset;

    // Start is only honoured where the FSM actually looks at it.
`ifdef AUTO_START_EN
    assign go_reset = (state_q == StIdle) || (state_q == StDone && start);
`else
    assign go_reset = (state_q == StIdle || state_q == StDone) && start;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            core_rst    <= 1'b0;
            running     <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            result      <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (go_reset) begin
                        state_q     <= StReset;
                        hold_q      <= '0;
                        core_rst    <= 1'b0;
                        running     <= 1'b0;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        timeout     <= 1'b0;
                        cycle_count <= '0;
                        result      <= '0;
                    end
                end
                StReset: begin
                    if (hold_q == HOLD_LAST) begin
                        state_q  <= StRun;
                        core_rst <= 1'b1;
                        running  <= 1'b1;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                StRun: begin
                    cycle_count <= cycle_count + CNT_W'(1);
                    // Halt takes priority over a budget that expires on the same edge.
                    if (halt) begin
                        state_q  <= StDone;
                        core_rst <= 1'b0;
                        running  <= 1'b0;
                        done     <= 1'b1;
                        result   <= halt_code;
                        pass     <= (halt_code == PASS_CODE);
                    end else if (cycle_count == CNT_LAST) begin
                        state_q  <= StDone;
                        core_rst <= 1'b0;
                        running  <= 1'b0;
                        done     <= 1'b1;
                        timeout  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: table of runs plus reset-timing and mid-run reset sequences.
module tb_run_controller;

    localparam int unsigned RST_HOLD   = 3;
    localparam int unsigned MAX_CYCLES = 20;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned SIG_W      = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             halt;
    logic [SIG_W-1:0] halt_code;
    logic             core_rst;
    logic             running;
    logic             done;
    logic             pass;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;
    logic [SIG_W-1:0] result;

    int checks = 0;
    int errors = 0;

    run_controller #(
        .RST_HOLD  (RST_HOLD),
        .MAX_CYCLES(MAX_CYCLES),
        .CNT_W     (CNT_W),
        .SIG_W     (SIG_W),
        .PASS_CODE (32'd1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .halt       (halt),
        .halt_code  (halt_code),
        .core_rst   (core_rst),
        .running    (running),
        .done       (done),
        .pass       (pass),
        .timeout    (timeout),
        .cycle_count(cycle_count),
        .result     (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          halt_at;   // RUN cycle carrying halt, 0 = never
        logic [31:0] code;
        logic        exp_pass;
        logic        exp_to;
        int          exp_cnt;
        logic [31:0] exp_res;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " core_rst"}, 32'(core_rst), 32'd0);
        chk({tag, " running"}, 32'(running), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " pass"}, 32'(pass), 32'd0);
        chk({tag, " timeout"}, 32'(timeout), 32'd0);
        chk({tag, " cycle_count"}, 32'(cycle_count), 32'd0);
        chk({tag, " result"}, result, 32'd0);
    endtask

    // Start pulse (or auto start) at edge N, reset hold, then run until done.
    task automatic run_vec(input int idx, input bit use_start);
        vec_t v;
        int   last;
        bit   fin;
        v    = vecs[idx];
        fin  = 1'b0;
        last = 0;
        if (use_start) start = 1'b1;
        tick();
        start = 1'b0;
        chk_all_zero($sformatf("v%0d entry", idx));
        for (int k = 0; k < int'(RST_HOLD); k++) begin
            tick();
            chk($sformatf("v%0d hold%0d core_rst", idx, k), 32'(core_rst), 32'd0);
            chk($sformatf("v%0d hold%0d running", idx, k), 32'(running), 32'd0);
        end
        tick();
        chk($sformatf("v%0d run core_rst", idx), 32'(core_rst), 32'd1);
        chk($sformatf("v%0d run running", idx), 32'(running), 32'd1);
        chk($sformatf("v%0d run count0", idx), 32'(cycle_count), 32'd0);
        for (int c = 1; c <= int'(MAX_CYCLES) + 2 && !fin; c++) begin
            halt      = (c == v.halt_at);
            halt_code = halt ? v.code : 32'hFFFF_FFFF;
            start     = (c == 2);
            tick();
            halt  = 1'b0;
            start = 1'b0;
            if (done) begin
                fin  = 1'b1;
                last = c;
            end else begin
                chk($sformatf("v%0d c%0d count", idx, c), 32'(cycle_count), 32'(c));
            end
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL v%0d done: got 0 expected 1 within %0d cycles", idx, MAX_CYCLES + 2);
        end else begin
            chk($sformatf("v%0d end cycle", idx), 32'(last), 32'(v.exp_cnt));
            chk($sformatf("v%0d cycle_count", idx), 32'(cycle_count), 32'(v.exp_cnt));
            chk($sformatf("v%0d pass", idx), 32'(pass), 32'(v.exp_pass));
            chk($sformatf("v%0d timeout", idx), 32'(timeout), 32'(v.exp_to));
            chk($sformatf("v%0d result", idx), result, v.exp_res);
            chk($sformatf("v%0d done core_rst", idx), 32'(core_rst), 32'd0);
            chk($sformatf("v%0d done running", idx), 32'(running), 32'd0);
            chk($sformatf("v%0d excl", idx), 32'(pass & timeout), 32'd0);
            // Halt in DONE must not disturb the latched verdict.
            halt      = 1'b1;
            halt_code = 32'h55;
            tick();
            halt = 1'b0;
            chk($sformatf("v%0d hold done", idx), 32'(done), 32'd1);
            chk($sformatf("v%0d hold result", idx), result, v.exp_res);
            chk($sformatf("v%0d hold count", idx), 32'(cycle_count), 32'(v.exp_cnt));
            chk($sformatf("v%0d hold core_rst", idx), 32'(core_rst), 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{halt_at: 10, code: 32'h1,    exp_pass: 1'b1, exp_to: 1'b0, exp_cnt: 10,
                    exp_res: 32'h1};
        vecs[1] = '{halt_at: 5,  code: 32'hDEAD, exp_pass: 1'b0, exp_to: 1'b0, exp_cnt: 5,
                    exp_res: 32'hDEAD};
        vecs[2] = '{halt_at: 0,  code: 32'h1,    exp_pass: 1'b0, exp_to: 1'b1, exp_cnt: 20,
                    exp_res: 32'h0};
        vecs[3] = '{halt_at: 20, code: 32'h1,    exp_pass: 1'b1, exp_to: 1'b0, exp_cnt: 20,
                    exp_res: 32'h1};
        vecs[4] = '{halt_at: 20, code: 32'h7,    exp_pass: 1'b0, exp_to: 1'b0, exp_cnt: 20,
                    exp_res: 32'h7};
        vecs[5] = '{halt_at: 1,  code: 32'h1,    exp_pass: 1'b1, exp_to: 1'b0, exp_cnt: 1,
                    exp_res: 32'h1};
        vecs[6] = '{halt_at: 19, code: 32'h0,    exp_pass: 1'b0, exp_to: 1'b0, exp_cnt: 19,
                    exp_res: 32'h0};

        rst       = 1'b0;
        start     = 1'b0;
        halt      = 1'b0;
        halt_code = '0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b1;

`ifdef AUTO_START_EN
        run_vec(0, 1'b0);
`else
        repeat (3) tick();
        chk("idle core_rst", 32'(core_rst), 32'd0);
        chk("idle running", 32'(running), 32'd0);
        chk("idle done", 32'(done), 32'd0);
        run_vec(0, 1'b1);
`endif
        for (int i = 1; i < 7; i++) run_vec(i, 1'b1);

        // Asynchronous reset in the middle of a run.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (RST_HOLD + 1 + 4) tick();
        chk("midrun running", 32'(running), 32'd1);
        chk("midrun count", 32'(cycle_count), 32'd4);
        #3 rst = 1'b0;
        #1 chk_all_zero("async");
        @(posedge clk);
        #1 rst = 1'b1;
`ifdef AUTO_START_EN
        run_vec(1, 1'b0);
`else
        repeat (4) tick();
        chk("post-rst running", 32'(running), 32'd0);
        chk("post-rst core_rst", 32'(core_rst), 32'd0);
        chk("post-rst done", 32'(done), 32'd0);
        run_vec(1, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
